// File: rtl/servo_pkg.sv
// Shared constants and FSM state type for the servo PWM generator.
package servo_pkg;

  localparam int CANT_BITS_DEF  = 13;
  localparam int PERIOD_CYC_DEF = 1_000_000;  // 20 ms at 50 MHz
  localparam int PULSE_MIN_DEF  = 50_000;     // 1.0 ms
  localparam int PULSE_MAX_DEF  = 100_000;    // 2.0 ms
  localparam int PULSE_CTR_DEF  = 75_000;     // 1.5 ms, reference 0
  localparam int SCALE_DEF      = 6;          // cycles per reference LSB

  localparam int CNT_W = $clog2(PERIOD_CYC_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/servo_ref_map.sv
// Signed reference -> pulse width: scale, add centre offset, clip to the
// legal servo range. Purely combinational.
module servo_ref_map
  import servo_pkg::*;
#(
  parameter int cant_bits = CANT_BITS_DEF,
  parameter int OUT_W     = CNT_W,
  parameter int PULSE_MIN = PULSE_MIN_DEF,
  parameter int PULSE_MAX = PULSE_MAX_DEF,
  parameter int PULSE_CTR = PULSE_CTR_DEF,
  parameter int SCALE     = SCALE_DEF
) (
  input  logic signed [cant_bits-1:0] ref_in,
  output logic        [OUT_W-1:0]     w,
  output logic                        sat
);

  // Product width, then one guard bit beyond the wider of the product and
  // the signed counter range so the offset add cannot overflow.
  localparam int PROD_W = cant_bits + $clog2(SCALE) + 1;
  localparam int SUM_W  = ((PROD_W > OUT_W + 1) ? PROD_W : OUT_W + 1) + 1;

  localparam logic signed [SUM_W-1:0] SCALE_S = SUM_W'(SCALE);
  localparam logic signed [SUM_W-1:0] CTR_S   = SUM_W'(PULSE_CTR);
  localparam logic signed [SUM_W-1:0] MIN_S   = SUM_W'(PULSE_MIN);
  localparam logic signed [SUM_W-1:0] MAX_S   = SUM_W'(PULSE_MAX);
  localparam logic        [OUT_W-1:0] MIN_U   = OUT_W'(PULSE_MIN);
  localparam logic        [OUT_W-1:0] MAX_U   = OUT_W'(PULSE_MAX);

  logic signed [SUM_W-1:0] ref_ext;
  logic signed [SUM_W-1:0] sum;

  // Linear map with saturation at both ends.
  always_comb begin
    ref_ext = {{(SUM_W - cant_bits){ref_in[cant_bits-1]}}, ref_in};
    sum     = ref_ext * SCALE_S + CTR_S;
    w       = sum[OUT_W-1:0];
    sat     = 1'b0;
    if (sum < MIN_S) begin
      w   = MIN_U;
      sat = 1'b1;
    end else if (sum > MAX_S) begin
      w   = MAX_U;
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Fixed-period servo PWM generator. Loaded widths are staged and only take
// effect at the next period boundary so a pulse is never reshaped mid-way.
//
//   state | meaning
//   IDLE  | output quiet, counter parked at 0, loads still staged
//   RUN   | counter sweeping 0..PERIOD_CYC-1, pulse while cnt < act_w
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int cant_bits  = CANT_BITS_DEF,
  parameter int PERIOD_CYC = PERIOD_CYC_DEF,
  parameter int PULSE_MIN  = PULSE_MIN_DEF,
  parameter int PULSE_MAX  = PULSE_MAX_DEF,
  parameter int PULSE_CTR  = PULSE_CTR_DEF,
  parameter int SCALE      = SCALE_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        En,
  input  logic signed [cant_bits-1:0] Datos_in,
  input  logic                        load,
  output logic                        pwm_out,
  output logic                        period_start,
  output logic                        upd_ack,
  output logic                        sat
);

  localparam int             CW    = $clog2(PERIOD_CYC);
  localparam logic [CW-1:0] LAST  = CW'(PERIOD_CYC - 1);
  localparam logic [CW-1:0] CTR_W = CW'(PULSE_CTR);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] act_w, act_w_n;
  logic [CW-1:0] pend_w;
  logic          pend;
  logic          start;
  logic [CW-1:0] map_w;
  logic          map_sat;

  servo_ref_map #(
    .cant_bits (cant_bits),
    .OUT_W     (CW),
    .PULSE_MIN (PULSE_MIN),
    .PULSE_MAX (PULSE_MAX),
    .PULSE_CTR (PULSE_CTR),
    .SCALE     (SCALE)
  ) u_ref_map (
    .ref_in (Datos_in),
    .w      (map_w),
    .sat    (map_sat)
  );

  // Next state, next count and period-boundary detection. Entering RUN from
  // IDLE counts as a boundary, so it can commit a staged width too.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    start   = 1'b0;
    case (state)
      IDLE: begin
        if (En) begin
          state_n = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (!En) begin
          state_n = IDLE;
        end else if (cnt == LAST) begin
          start = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    act_w_n = (start && pend) ? pend_w : act_w;
  end

  // State, counter, width staging and registered outputs. Outputs are
  // computed from next-cycle values so they line up with cnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      act_w        <= CTR_W;
      pend_w       <= CTR_W;
      pend         <= 1'b0;
      sat          <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      upd_ack      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      act_w        <= act_w_n;
      period_start <= start;
      upd_ack      <= start & pend;
      pwm_out      <= (state_n == RUN) && (cnt_n < act_w_n);
      // A load on a boundary edge stages for the following boundary; the
      // width committed on this edge is the previously staged one.
      if (load) begin
        pend_w <= map_w;
        sat    <= map_sat;
        pend   <= 1'b1;
      end else if (start) begin
        pend   <= 1'b0;
      end
    end
  end

endmodule
